// File: rtl/bic_frame_rx.sv
// bic_frame_rx -- serial frame receiver for the bi-directional chat link.
//
// Counts bit-sample strobes (srClock qualified by recEn), detects the start
// bit, shifts in DATA_BITS data bits LSB first, checks an optional parity bit
// and STOP_BITS stop bits, then delivers the character with a valid/ack
// handshake and frame/parity/overrun status.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   srClock   one-cycle bit-sample strobe
//   recEn     receive enable; low aborts a frame in progress
//   serIn     synchronised serial line, idle high
//   rdAck     consumer acknowledge; clears dataValid and overrun
//   data      last received character
//   charRec   one-cycle pulse on frame completion
//   dataValid unread character held in data
//   frameErr  a stop bit sampled 0 in the last frame
//   parityErr parity mismatch in the last frame
//   overrun   a frame completed while dataValid was still set
//   busy      receiver is not idle
//   bitCount  strobes consumed in the current frame
module bic_frame_rx #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   localparam int FRAME     = 1 + DATA_BITS + PARITY_EN + STOP_BITS,
   localparam int CW        = $clog2(FRAME + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 srClock,
   input  logic                 recEn,
   input  logic                 serIn,
   input  logic                 rdAck,
   output logic [DATA_BITS-1:0] data,
   output logic                 charRec,
   output logic                 dataValid,
   output logic                 frameErr,
   output logic                 parityErr,
   output logic                 overrun,
   output logic                 busy,
   output logic [CW-1:0]        bitCount
);

   localparam logic          PAR_ON     = (PARITY_EN != 0);
   localparam logic          PAR_ODD    = (PARITY_ODD != 0);
   localparam logic [CW-1:0] LAST_DATA  = CW'(DATA_BITS);
   localparam logic [CW-1:0] LAST_FRAME = CW'(FRAME - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t                 state_reg, state_next;
   logic [CW-1:0]          count_reg, count_next;
   logic [DATA_BITS-1:0]   shift_reg, shift_next;
   logic                   ferr_int_reg, ferr_int_next;
   logic                   perr_int_reg, perr_int_next;
   logic [DATA_BITS-1:0]   data_reg, data_next;
   logic                   char_rec_reg, char_rec_next;
   logic                   valid_reg, valid_next;
   logic                   frame_err_reg, frame_err_next;
   logic                   parity_err_reg, parity_err_next;
   logic                   overrun_reg, overrun_next;
   logic                   busy_reg, busy_next;

   // Shift register moves right; the new sample enters at the MSB so that
   // after DATA_BITS samples the first (LSB) bit sits at index 0.
   logic [DATA_BITS-1:0]   shift_in;

   assign shift_in[DATA_BITS-1] = serIn;
   generate
      for (genvar gi = 0; gi < DATA_BITS - 1; gi++) begin : g_shift
         assign shift_in[gi] = shift_reg[gi+1];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         count_reg      <= '0;
         shift_reg      <= '0;
         ferr_int_reg   <= 1'b0;
         perr_int_reg   <= 1'b0;
         data_reg       <= '0;
         char_rec_reg   <= 1'b0;
         valid_reg      <= 1'b0;
         frame_err_reg  <= 1'b0;
         parity_err_reg <= 1'b0;
         overrun_reg    <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         shift_reg      <= shift_next;
         ferr_int_reg   <= ferr_int_next;
         perr_int_reg   <= perr_int_next;
         data_reg       <= data_next;
         char_rec_reg   <= char_rec_next;
         valid_reg      <= valid_next;
         frame_err_reg  <= frame_err_next;
         parity_err_reg <= parity_err_next;
         overrun_reg    <= overrun_next;
         busy_reg       <= busy_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      count_next      = count_reg;
      shift_next      = shift_reg;
      ferr_int_next   = ferr_int_reg;
      perr_int_next   = perr_int_reg;
      data_next       = data_reg;
      char_rec_next   = 1'b0;
      valid_next      = valid_reg;
      frame_err_next  = frame_err_reg;
      parity_err_next = parity_err_reg;
      overrun_next    = overrun_reg;

      // Acknowledge is applied first so that a completion in the same cycle
      // overrides it and leaves the new character valid.
      if (rdAck) begin
         valid_next   = 1'b0;
         overrun_next = 1'b0;
      end

      if (!recEn) begin
         state_next    = IDLE;
         count_next    = '0;
         shift_next    = '0;
         ferr_int_next = 1'b0;
         perr_int_next = 1'b0;
      end else if (srClock) begin
         case (state_reg)
            IDLE: begin
               if (!serIn) begin
                  state_next = DATA;
                  count_next = CW'(1);
               end
            end
            DATA: begin
               shift_next = shift_in;
               count_next = count_reg + CW'(1);
               if (count_reg == LAST_DATA)
                  state_next = PAR_ON ? PARITY : STOP;
            end
            PARITY: begin
               perr_int_next = (^shift_reg) ^ serIn ^ PAR_ODD;
               count_next    = count_reg + CW'(1);
               state_next    = STOP;
            end
            STOP: begin
               if (count_reg == LAST_FRAME) begin
                  // Final stop sample: its value folds directly into frameErr.
                  data_next       = shift_reg;
                  frame_err_next  = ferr_int_reg | ~serIn;
                  parity_err_next = PAR_ON & perr_int_reg;
                  char_rec_next   = 1'b1;
                  valid_next      = 1'b1;
                  overrun_next    = valid_reg & ~rdAck;
                  state_next      = IDLE;
                  count_next      = '0;
                  shift_next      = '0;
                  ferr_int_next   = 1'b0;
                  perr_int_next   = 1'b0;
               end else begin
                  ferr_int_next = ferr_int_reg | ~serIn;
                  count_next    = count_reg + CW'(1);
               end
            end
            default: begin
               state_next = IDLE;
               count_next = '0;
            end
         endcase
      end

      busy_next = (state_next != IDLE);
   end

   assign data      = data_reg;
   assign charRec   = char_rec_reg;
   assign dataValid = valid_reg;
   assign frameErr  = frame_err_reg;
   assign parityErr = parity_err_reg;
   assign overrun   = overrun_reg;
   assign busy      = busy_reg;
   assign bitCount  = count_reg;

endmodule
